imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter ADDR_W, default 13, instruction address width (matches the PC width).
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 Parameter LATENCY, default 2, read latency in cycles; legal range 1..4.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  fetch requests an instruction read.
REQ-007 req_addr  in  ADDR_W  word address of the requested instruction.
REQ-008 req_ready  out  1  responder accepts the request this cycle.
REQ-009 resp_valid  out  1  resp_instr and resp_addr are valid.
REQ-010 resp_instr  out  DATA_W  instruction word read.
REQ-011 resp_addr  out  ADDR_W  echo of the accepted req_addr.
REQ-012 resp_ready  in  1  fetch consumes the response.
REQ-013 load_en  in  1  program-load write strobe.
REQ-014 load_addr  in  ADDR_W  program-load word address.
REQ-015 load_data  in  DATA_W  program-load word.
REQ-016 load_ready  out  1  a load write is accepted this cycle.

Function
REQ-017 Storage SHALL be 2**ADDR_W words of DATA_W bits; the full address space is used and no wrap logic is needed.
REQ-018 FSM states SHALL be IDLE, READ and RESP.
REQ-019 load_ready SHALL be 1 exactly when the state is IDLE.
REQ-020 req_ready SHALL be 1 exactly when the state is IDLE and load_en=0, so a load wins over a simultaneous request.
REQ-021 When load_en=1 and load_ready=1, load_data SHALL be written to load_addr at that edge.
REQ-022 When load_en=1 outside IDLE, the write SHALL be dropped and the storage left unchanged.
REQ-023 When req_valid=1 and req_ready=1 at an edge (the acceptance edge), req_addr SHALL be latched, a latency counter loaded, and the state SHALL go to READ.
REQ-024 The array SHALL be read at the latched address.
REQ-025 resp_valid SHALL first be 1 in the cycle that begins exactly LATENCY edges after the acceptance edge, and the state SHALL be RESP at that point.
REQ-026 In RESP, resp_valid, resp_instr and resp_addr SHALL hold stable until resp_ready=1 at an edge.
REQ-027 On that resp_ready edge the state SHALL return to IDLE, so req_ready is 1 in the next cycle at the earliest.
REQ-028 There is at most one outstanding request; sustained throughput is one word per LATENCY+1 cycles.
REQ-029 resp_ready while resp_valid=0 SHALL be ignored.
REQ-030 A changing req_addr after acceptance SHALL NOT affect the response.
REQ-031 Loads are blocked outside IDLE, so a read SHALL always return the contents present at acceptance.

Reset
REQ-032 While rst=1 at an edge: state IDLE, resp_valid=0, resp_instr=0, resp_addr=0, counter=0.
REQ-033 After reset, req_ready and load_ready SHALL be 1 in the next cycle.
REQ-034 Reset in READ or RESP SHALL abandon the request, and no response for it SHALL ever appear.
REQ-035 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-036 ADDR_W/DATA_W defaults, the LATENCY bounds and the FSM state encoding SHALL live in a shared package imem_pkg.
REQ-037 The storage SHALL be one sub-module, imem_array: one synchronous write port and one read port.
REQ-038 FSM, counter and handshake logic SHALL stay in imem_responder.

Verification
REQ-039 Load 0x0000<-16'h1234 and 0x0001<-16'hABCD; request 0x0001 with resp_ready=1 -> resp_valid exactly 2 cycles after acceptance with resp_instr=16'hABCD and resp_addr=0x0001.
REQ-040 Request 0x0000 with resp_ready=0 for 5 cycles -> resp_instr=16'h1234 held stable; req_ready=0 throughout; IDLE the cycle after resp_ready=1.
REQ-041 load_en and req_valid both asserted in IDLE -> write occurs, req_ready=0 that cycle, request accepted the next cycle.
REQ-042 load_en=1 (0x0000<-16'hFFFF) during READ -> load_ready=0, then a later read of 0x0000 returns 16'h1234.
REQ-043 Assert rst in the cycle before resp_valid would rise -> no resp_valid appears, outputs are 0, and contents at 0x0001 are still 16'hABCD.
REQ-044 Highest address 0x1FFF loaded with 16'h5A5A, with LATENCY=1 and LATENCY=4 builds -> correct data returned at each latency.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared widths, latency bounds and FSM encoding for the instruction memory responder.
package imem_pkg;

  localparam int IMEM_ADDR_W  = 13;
  localparam int IMEM_DATA_W  = 16;
  localparam int IMEM_LAT_MIN = 1;
  localparam int IMEM_LAT_MAX = 4;
  localparam int IMEM_CNT_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

  // Counter preload for a given latency; out-of-range values are clamped.
  function automatic logic [IMEM_CNT_W-1:0] lat_preload(int lat);
    int clamped;
    clamped = (lat < IMEM_LAT_MIN) ? IMEM_LAT_MIN :
              (lat > IMEM_LAT_MAX) ? IMEM_LAT_MAX : lat;
    return IMEM_CNT_W'(clamped - 1);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response and program-load bundle between the core and the instruction memory.
interface imem_responder_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
);

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_instr;
  logic [ADDR_W-1:0] resp_addr;
  logic              resp_ready;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;

  modport master (
    output req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
    input  req_ready, resp_valid, resp_instr, resp_addr, load_ready
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
    output req_ready, resp_valid, resp_instr, resp_addr, load_ready
  );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one registered read port, no reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with fixed read latency and an IDLE-only load port.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int DATA_W  = IMEM_DATA_W,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  imem_responder_if.slave  bus
);

  imem_state_e             state_q, state_d;
  logic [IMEM_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       rd_data;
  logic                    idle, accept, write_en, cnt_done, resp_valid;

  assign idle     = (state_q == ST_IDLE);
  assign accept   = idle && !bus.load_en && bus.req_valid;
  assign write_en = idle && bus.load_en;
  assign cnt_done = (cnt_q == '0);

  // Reads always use the latched address; writes only happen in IDLE, so the
  // registered read data stays stable through READ and RESP.
  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (write_en),
    .waddr_i (bus.load_addr),
    .wdata_i (bus.load_data),
    .raddr_i (addr_q),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)         state_d = ST_READ;
      ST_READ: if (cnt_done)       state_d = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (accept) begin
      cnt_d  = lat_preload(LATENCY);
      addr_d = bus.req_addr;
    end else if ((state_q == ST_READ) && !cnt_done) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    resp_valid     = (state_q == ST_RESP);
    bus.resp_valid = resp_valid;
    bus.load_ready = idle;
    bus.req_ready  = idle && !bus.load_en;
    bus.resp_instr = resp_valid ? rd_data : '0;
    bus.resp_addr  = resp_valid ? addr_q  : '0;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Drives three responders (latency 2, 1, 4) with shared stimulus and checks each against a timing model.
module tb_imem_responder;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam int N  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, resp_ready, load_en;
  logic [AW-1:0] req_addr, load_addr;
  logic [DW-1:0] load_data;

  logic [N-1:0]  o_req_ready, o_load_ready, o_resp_valid;
  logic [DW-1:0] o_instr [N];
  logic [AW-1:0] o_addr  [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
      imem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
      assign bus.req_valid    = req_valid;
      assign bus.req_addr     = req_addr;
      assign bus.resp_ready   = resp_ready;
      assign bus.load_en      = load_en;
      assign bus.load_addr    = load_addr;
      assign bus.load_data    = load_data;
      assign o_req_ready[gi]  = bus.req_ready;
      assign o_load_ready[gi] = bus.load_ready;
      assign o_resp_valid[gi] = bus.resp_valid;
      assign o_instr[gi]      = bus.resp_instr;
      assign o_addr[gi]       = bus.resp_addr;
      imem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  // Reference model: one outstanding fetch per instance, response due LATENCY
  // cycles after the cycle following acceptance.
  int            lat_m [N] = '{2, 1, 4};
  logic [DW-1:0] mem_m [N][2**AW];
  bit            busy_m [N];
  int            t_acc_m [N];
  logic [AW-1:0] a_m [N];
  logic [DW-1:0] d_m [N];
  int            cyc = 0;
  bit            chk_en = 1'b0;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(bit r, bit le, logic [AW-1:0] la, logic [DW-1:0] ld,
                      bit rv, logic [AW-1:0] ra, bit rr);
    bit            ev;
    logic [DW-1:0] ei;
    logic [AW-1:0] ea;
    rst = r; load_en = le; load_addr = la; load_data = ld;
    req_valid = rv; req_addr = ra; resp_ready = rr;
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        ev = busy_m[i] && (cyc >= t_acc_m[i] + lat_m[i]);
        ei = ev ? d_m[i] : '0;
        ea = ev ? a_m[i] : '0;
        check($sformatf("load_ready[L%0d] c%0d", lat_m[i], cyc), 32'(o_load_ready[i]), 32'(!busy_m[i]));
        check($sformatf("req_ready[L%0d] c%0d", lat_m[i], cyc), 32'(o_req_ready[i]), 32'(!busy_m[i] && !le));
        check($sformatf("resp_valid[L%0d] c%0d", lat_m[i], cyc), 32'(o_resp_valid[i]), 32'(ev));
        check($sformatf("resp_instr[L%0d] c%0d", lat_m[i], cyc), 32'(o_instr[i]), 32'(ei));
        check($sformatf("resp_addr[L%0d] c%0d", lat_m[i], cyc), 32'(o_addr[i]), 32'(ea));
      end
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (r) begin
        busy_m[i] = 1'b0;
      end else if (!busy_m[i]) begin
        if (le) begin
          mem_m[i][la] = ld;
        end else if (rv) begin
          busy_m[i]  = 1'b1;
          t_acc_m[i] = cyc + 1;
          a_m[i]     = ra;
          d_m[i]     = mem_m[i][ra];
        end
      end else if ((cyc >= t_acc_m[i] + lat_m[i]) && rr) begin
        busy_m[i] = 1'b0;
      end
    end
    if (r) chk_en = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic idle_cycles(int n, bit rr);
    for (int k = 0; k < n; k++) step(0, 0, '0, '0, 0, '0, rr);
  endtask

  function automatic logic [AW-1:0] pool_addr(int k);
    case (k)
      0:       return 13'h0000;
      1:       return 13'h0001;
      2:       return 13'h0002;
      3:       return 13'h0003;
      4:       return 13'h0AAA;
      5:       return 13'h1555;
      6:       return 13'h1FFE;
      default: return 13'h1FFF;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < N; i++) busy_m[i] = 1'b0;
    step(1, 0, '0, '0, 0, '0, 0);
    step(1, 0, '0, '0, 0, '0, 0);

    // Preload every pool address so all reads have defined contents.
    for (int k = 2; k < 7; k++) step(0, 1, pool_addr(k), DW'($urandom), 0, '0, 0);
    step(0, 1, 13'h0000, 16'h1234, 0, '0, 0);
    step(0, 1, 13'h0001, 16'hABCD, 0, '0, 0);
    step(0, 1, 13'h1FFF, 16'h5A5A, 0, '0, 0);

    // Basic fetch with resp_ready held high.
    step(0, 0, '0, '0, 1, 13'h0001, 1);
    idle_cycles(6, 1);

    // Response held with resp_ready low, address changing after acceptance.
    step(0, 0, '0, '0, 1, 13'h0000, 0);
    for (int k = 0; k < 7; k++) step(0, 0, '0, '0, 1, pool_addr(k), 0);
    idle_cycles(2, 1);

    // Load and request together: load wins, request accepted next cycle.
    step(0, 1, 13'h0002, 16'h7777, 1, 13'h0002, 0);
    step(0, 0, '0, '0, 1, 13'h0002, 1);
    idle_cycles(6, 1);

    // Load attempted while busy is dropped.
    step(0, 0, '0, '0, 1, 13'h0001, 0);
    step(0, 1, 13'h0000, 16'hFFFF, 0, '0, 0);
    idle_cycles(6, 1);
    step(0, 0, '0, '0, 1, 13'h0000, 1);
    idle_cycles(6, 1);

    // Reset in the cycle before the latency-2 response would appear.
    step(0, 0, '0, '0, 1, 13'h0001, 0);
    step(0, 0, '0, '0, 0, '0, 0);
    step(1, 0, '0, '0, 0, '0, 0);
    idle_cycles(6, 1);
    step(0, 0, '0, '0, 1, 13'h0001, 1);
    idle_cycles(6, 1);

    // Highest address at every latency.
    step(0, 0, '0, '0, 1, 13'h1FFF, 1);
    idle_cycles(6, 1);

    // Randomised traffic including occasional resets.
    for (int k = 0; k < 3000; k++) begin
      bit r, le, rv, rr;
      r  = ($urandom_range(99) < 1);
      le = !r && ($urandom_range(99) < 15);
      rv = !r && ($urandom_range(1) == 1);
      rr = ($urandom_range(1) == 1);
      step(r, le, pool_addr($urandom_range(7)), DW'($urandom), rv, pool_addr($urandom_range(7)), rr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
